// File: rtl/sent_rx_line_cond_pkg.sv
// Shared constants and helpers for the SENT receive line conditioner.
// CALIB_TICKS is the length of the SENT calibration pulse in ticks. The
// calibration window is CALIB_TICKS*tick_clks scaled by WIN_LO_NUM/WIN_DEN
// and WIN_HI_NUM/WIN_DEN, which gives +/-20 % tolerance.
package sent_rx_line_cond_pkg;

  localparam int CALIB_TICKS = 56;
  localparam int WIN_LO_NUM  = 4;
  localparam int WIN_HI_NUM  = 6;
  localparam int WIN_DEN     = 5;

  localparam int PULSE_W   = 16;
  localparam int TICK_W    = 10;
  localparam int TICK_MAX  = (1 << TICK_W) - 1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } meas_state_e;

  // Integer window bounds, in clk_rx cycles.
  function automatic int win_lo(input int tick_clks);
    return (CALIB_TICKS * tick_clks * WIN_LO_NUM) / WIN_DEN;
  endfunction

  function automatic int win_hi(input int tick_clks);
    return (CALIB_TICKS * tick_clks * WIN_HI_NUM) / WIN_DEN;
  endfunction

endpackage

// File: rtl/sent_rx_line_cond_if.sv
// Signal bundle between the line conditioner and its consumer.
//   master : the conditioner (takes the raw line, drives the results)
//   slave  : the consumer / line source
//   sent_rx_i      raw asynchronous SENT line
//   sent_clean_o   synchronized, glitch-filtered level
//   fall_o         strobe per filtered falling edge
//   pulse_valid_o  strobe per completed fall-to-fall interval
//   pulse_len_o    interval length in clk_rx cycles
//   pulse_ovf_o    interval saturated
//   calib_o        strobe when interval is a calibration pulse
//   tick_len_o     measured clk_rx cycles per tick
//   tick_valid_o   tick_len_o holds a measured value
interface sent_rx_line_cond_if;
  import sent_rx_line_cond_pkg::*;

  logic               sent_rx_i;
  logic               sent_clean_o;
  logic               fall_o;
  logic               pulse_valid_o;
  logic [PULSE_W-1:0] pulse_len_o;
  logic               pulse_ovf_o;
  logic               calib_o;
  logic [TICK_W-1:0]  tick_len_o;
  logic               tick_valid_o;

  modport master (
    input  sent_rx_i,
    output sent_clean_o, fall_o, pulse_valid_o, pulse_len_o, pulse_ovf_o,
           calib_o, tick_len_o, tick_valid_o
  );

  modport slave (
    output sent_rx_i,
    input  sent_clean_o, fall_o, pulse_valid_o, pulse_len_o, pulse_ovf_o,
           calib_o, tick_len_o, tick_valid_o
  );

endinterface

// File: rtl/sent_rx_div56.sv
// Sequential restoring divider: tick_len = (len + CALIB_TICKS/2) / CALIB_TICKS.
// One quotient bit per cycle over PULSE_W cycles; result published on the
// cycle after the last step, i.e. PULSE_W+1 cycles after start_i.
// A start_i while busy reloads the operands (latest request wins).
// Ports:
//   clk_rx, reset_n_rx  clock, async active-low reset
//   start_i             load len_i and begin dividing
//   len_i               interval length in clk_rx cycles
//   tick_len_o          rounded quotient, saturated to TICK_MAX
//   tick_valid_o        set on first published result
module sent_rx_div56
  import sent_rx_line_cond_pkg::*;
(
  input  logic               clk_rx,
  input  logic               reset_n_rx,
  input  logic               start_i,
  input  logic [PULSE_W-1:0] len_i,
  output logic [TICK_W-1:0]  tick_len_o,
  output logic               tick_valid_o
);

  localparam int REM_W  = $clog2(CALIB_TICKS);
  localparam int STEP_W = $clog2(PULSE_W + 1);
  localparam logic [REM_W:0] DIVISOR = (REM_W + 1)'(CALIB_TICKS);

  logic               busy;
  logic [STEP_W-1:0]  step_cnt;
  logic [REM_W-1:0]   rem;
  logic [PULSE_W-1:0] quo;
  logic [PULSE_W-1:0] dvd;

  logic [PULSE_W:0]   sum;
  logic [REM_W:0]     trial;
  logic               qbit;
  logic [REM_W-1:0]   rem_nxt;
  logic [PULSE_W-1:0] quo_nxt;

  // Bit PULSE_W of the rounded dividend is always below the divisor, so it
  // seeds the remainder directly and only PULSE_W steps remain.
  assign sum     = {1'b0, len_i} + (PULSE_W + 1)'(CALIB_TICKS / 2);
  assign trial   = {rem, dvd[PULSE_W-1]};
  assign qbit    = (trial >= DIVISOR);
  assign rem_nxt = qbit ? REM_W'(trial - DIVISOR) : trial[REM_W-1:0];
  assign quo_nxt = {quo[PULSE_W-2:0], qbit};

  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) begin
      busy         <= 1'b0;
      step_cnt     <= '0;
      rem          <= '0;
      quo          <= '0;
      dvd          <= '0;
      tick_len_o   <= '0;
      tick_valid_o <= 1'b0;
    end else if (start_i) begin
      busy     <= 1'b1;
      step_cnt <= STEP_W'(PULSE_W);
      rem      <= REM_W'(sum[PULSE_W]);
      quo      <= '0;
      dvd      <= sum[PULSE_W-1:0];
    end else if (busy) begin
      rem      <= rem_nxt;
      quo      <= quo_nxt;
      dvd      <= {dvd[PULSE_W-2:0], 1'b0};
      step_cnt <= step_cnt - 1'b1;
      if (step_cnt == STEP_W'(1)) begin
        busy         <= 1'b0;
        tick_valid_o <= 1'b1;
        tick_len_o   <= (quo_nxt > PULSE_W'(TICK_MAX)) ? TICK_W'(TICK_MAX)
                                                        : quo_nxt[TICK_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sent_rx_line_cond.sv
// SENT receive line conditioner: two-flop synchronizer, FILT_LEN-sample
// glitch filter, falling-edge detector, fall-to-fall interval measurement
// with saturation, calibration-window detection and tick-length division.
// Ports:
//   clk_rx      single clock
//   reset_n_rx  async active-low reset
//   bus         sent_rx_line_cond_if.master (raw line in, results out)
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | no reference edge yet; wait for the first fall_o
// ST_MEASURE | counting cycles since the last fall_o
module sent_rx_line_cond
  import sent_rx_line_cond_pkg::*;
#(
  parameter int FILT_LEN  = 3,
  parameter int TICK_CLKS = 30
) (
  input  logic                 clk_rx,
  input  logic                 reset_n_rx,
  sent_rx_line_cond_if.master  bus
);

  localparam logic [2:0]         FILT_CNT_MAX = 3'(FILT_LEN - 1);
  localparam logic [31:0]        WIN_LO       = 32'(win_lo(TICK_CLKS));
  localparam logic [31:0]        WIN_HI       = 32'(win_hi(TICK_CLKS));
  localparam logic [PULSE_W-1:0] CNT_SAT      = '1;

  logic sync_q1, sync_q2;
  logic clean_q, clean_prev;
  logic [2:0] filt_cnt;
  logic fall_q;

  meas_state_e        state;
  logic [PULSE_W-1:0] meas_cnt;
  logic               valid_q;
  logic [PULSE_W-1:0] len_q;
  logic               ovf_q;
  logic               calib_q;
  logic               in_win;

  // Synchronizer and filter idle high, matching an idle SENT line.
  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) begin
      sync_q1    <= 1'b1;
      sync_q2    <= 1'b1;
      clean_q    <= 1'b1;
      clean_prev <= 1'b1;
      filt_cnt   <= '0;
      fall_q     <= 1'b0;
    end else begin
      sync_q1    <= bus.sent_rx_i;
      sync_q2    <= sync_q1;
      clean_prev <= clean_q;
      fall_q     <= clean_prev & ~clean_q;
      // Any sample equal to the current level restarts the run.
      if (sync_q2 != clean_q) begin
        if (filt_cnt == FILT_CNT_MAX) begin
          clean_q  <= sync_q2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 3'd1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign in_win = (32'(meas_cnt) >= WIN_LO) && (32'(meas_cnt) <= WIN_HI);

  always_ff @(posedge clk_rx or negedge reset_n_rx) begin
    if (!reset_n_rx) begin
      state    <= ST_IDLE;
      meas_cnt <= '0;
      valid_q  <= 1'b0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      calib_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      calib_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fall_q) begin
            meas_cnt <= PULSE_W'(1);
            state    <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (fall_q) begin
            valid_q  <= 1'b1;
            len_q    <= meas_cnt;
            ovf_q    <= (meas_cnt == CNT_SAT);
            calib_q  <= in_win && (meas_cnt != CNT_SAT);
            meas_cnt <= PULSE_W'(1);
          end else if (meas_cnt != CNT_SAT) begin
            meas_cnt <= meas_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  sent_rx_div56 u_div56 (
    .clk_rx       (clk_rx),
    .reset_n_rx   (reset_n_rx),
    .start_i      (calib_q),
    .len_i        (len_q),
    .tick_len_o   (bus.tick_len_o),
    .tick_valid_o (bus.tick_valid_o)
  );

  assign bus.sent_clean_o  = clean_q;
  assign bus.fall_o        = fall_q;
  assign bus.pulse_valid_o = valid_q;
  assign bus.pulse_len_o   = len_q;
  assign bus.pulse_ovf_o   = ovf_q;
  assign bus.calib_o       = calib_q;

endmodule

// File: tb/tb_sent_rx_line_cond.sv
module tb_sent_rx_line_cond;

  logic clk_rx = 1'b0;
  logic reset_n_rx;
  always #5 clk_rx = ~clk_rx;

  sent_rx_line_cond_if bus ();

  sent_rx_line_cond #(.FILT_LEN(3), .TICK_CLKS(30)) dut (
    .clk_rx     (clk_rx),
    .reset_n_rx (reset_n_rx),
    .bus        (bus)
  );

  // Divider alone, for back-to-back restarts the line cannot produce.
  logic        div_start;
  logic [15:0] div_len;
  logic [9:0]  div_tick;
  logic        div_tv;

  sent_rx_div56 u_div (
    .clk_rx       (clk_rx),
    .reset_n_rx   (reset_n_rx),
    .start_i      (div_start),
    .len_i        (div_len),
    .tick_len_o   (div_tick),
    .tick_valid_o (div_tv)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk_rx) cyc++;

  int   fall_cnt    = 0;
  int   calib_cyc   = 0;
  int   tv_rise_cyc = -1;
  logic tv_prev     = 1'b0;
  bit   div_saw_30  = 1'b0;
  int   div_pub_cyc = -1;
  logic div_tv_prev = 1'b0;

  always @(negedge clk_rx) begin
    if (bus.fall_o === 1'b1) fall_cnt++;
    if (bus.calib_o === 1'b1) calib_cyc = cyc;
    if (bus.tick_valid_o === 1'b1 && !tv_prev && tv_rise_cyc < 0) tv_rise_cyc = cyc;
    tv_prev = bus.tick_valid_o;
    if (div_tv === 1'b1 && div_tick == 10'd30) div_saw_30 = 1'b1;
    if (div_tv === 1'b1 && !div_tv_prev && div_pub_cyc < 0) div_pub_cyc = cyc;
    div_tv_prev = div_tv;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Falling edge now, low for 20 cycles, then high; next call falls n cycles later.
  task automatic pulse(input int n, input bit exp_valid, input int exp_len,
                       input bit exp_ovf, input bit exp_calib, input string tag);
    bit          seen    = 1'b0;
    logic [15:0] got_len = '0;
    logic        got_ovf = 1'b0;
    logic        got_cal = 1'b0;
    bus.sent_rx_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_rx);
      if (bus.pulse_valid_o === 1'b1 && !seen) begin
        seen    = 1'b1;
        got_len = bus.pulse_len_o;
        got_ovf = bus.pulse_ovf_o;
        got_cal = bus.calib_o;
      end
    end
    check_val({tag, "_valid"}, 32'(seen), 32'(exp_valid));
    if (exp_valid && seen) begin
      check_val({tag, "_len"},   32'(got_len), 32'(exp_len));
      check_val({tag, "_ovf"},   32'(got_ovf), 32'(exp_ovf));
      check_val({tag, "_calib"}, 32'(got_cal), 32'(exp_calib));
    end
    bus.sent_rx_i = 1'b1;
    repeat (n - 20) @(negedge clk_rx);
  endtask

  int f0;
  int s2;

  initial begin
    reset_n_rx    = 1'b0;
    bus.sent_rx_i = 1'b1;
    div_start     = 1'b0;
    div_len       = '0;
    repeat (3) @(negedge clk_rx);

    check_val("rst_clean",   32'(bus.sent_clean_o),  32'd1);
    check_val("rst_fall",    32'(bus.fall_o),        32'd0);
    check_val("rst_valid",   32'(bus.pulse_valid_o), 32'd0);
    check_val("rst_len",     32'(bus.pulse_len_o),   32'd0);
    check_val("rst_ovf",     32'(bus.pulse_ovf_o),   32'd0);
    check_val("rst_calib",   32'(bus.calib_o),       32'd0);
    check_val("rst_tick",    32'(bus.tick_len_o),    32'd0);
    check_val("rst_tvalid",  32'(bus.tick_valid_o),  32'd0);
    reset_n_rx = 1'b1;
    repeat (5) @(negedge clk_rx);

    // 2-cycle glitch must not pass a 3-sample filter.
    f0 = fall_cnt;
    bus.sent_rx_i = 1'b0;
    repeat (2) @(negedge clk_rx);
    bus.sent_rx_i = 1'b1;
    repeat (12) @(negedge clk_rx);
    check_val("glitch_falls", 32'(fall_cnt - f0), 32'd0);
    check_val("glitch_clean", 32'(bus.sent_clean_o), 32'd1);

    pulse(1680, 1'b0, 0, 1'b0, 1'b0, "first");
    check_val("first_fall_seen", 32'(fall_cnt - f0), 32'd1);
    pulse(1343, 1'b1, 1680, 1'b0, 1'b1, "p1680");
    check_val("tick_1680",    32'(bus.tick_len_o),   32'd30);
    check_val("tvalid_1680",  32'(bus.tick_valid_o), 32'd1);
    check_val("tick_latency", 32'(tv_rise_cyc - calib_cyc), 32'd17);
    pulse(2017, 1'b1, 1343, 1'b0, 1'b0, "p1343");
    check_val("tick_hold_1343", 32'(bus.tick_len_o), 32'd30);
    pulse(1344, 1'b1, 2017, 1'b0, 1'b0, "p2017");
    pulse(2016, 1'b1, 1344, 1'b0, 1'b1, "p1344");
    check_val("tick_1344", 32'(bus.tick_len_o), 32'd24);
    pulse(70000, 1'b1, 2016, 1'b0, 1'b1, "p2016");
    check_val("tick_2016", 32'(bus.tick_len_o), 32'd36);
    pulse(500, 1'b1, 65535, 1'b1, 1'b0, "povf");
    check_val("tick_after_ovf", 32'(bus.tick_len_o), 32'd36);

    // One-cycle reset while measuring, line high.
    repeat (50) @(negedge clk_rx);
    reset_n_rx = 1'b0;
    @(negedge clk_rx);
    check_val("mrst_len",    32'(bus.pulse_len_o),   32'd0);
    check_val("mrst_ovf",    32'(bus.pulse_ovf_o),   32'd0);
    check_val("mrst_tick",   32'(bus.tick_len_o),    32'd0);
    check_val("mrst_tvalid", 32'(bus.tick_valid_o),  32'd0);
    check_val("mrst_clean",  32'(bus.sent_clean_o),  32'd1);
    reset_n_rx = 1'b1;
    repeat (5) @(negedge clk_rx);
    pulse(300, 1'b0, 0,   1'b0, 1'b0, "post_rst1");
    pulse(400, 1'b1, 300, 1'b0, 1'b0, "post_rst2");
    pulse(100, 1'b1, 400, 1'b0, 1'b0, "post_rst3");

    // Divider restart: 1680 then 1800 five cycles later; only 32 published.
    div_start = 1'b1;
    div_len   = 16'd1680;
    @(negedge clk_rx);
    div_start = 1'b0;
    repeat (4) @(negedge clk_rx);
    div_start = 1'b1;
    div_len   = 16'd1800;
    s2 = cyc;
    @(negedge clk_rx);
    div_start = 1'b0;
    repeat (30) @(negedge clk_rx);
    check_val("div_no_stale", 32'(div_saw_30), 32'd0);
    check_val("div_tick",     32'(div_tick),   32'd32);
    check_val("div_tvalid",   32'(div_tv),     32'd1);
    check_val("div_latency",  32'(div_pub_cyc - s2), 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sent_rx_line_cond.md
SENT_RX_LINE_COND -- requirements
Module: sent_rx_line_cond

Interface
REQ-001 SHALL have parameter FILT_LEN, default 3, meaning consecutive equal synchronized samples required before the filtered line changes (range 1..7).
REQ-002 SHALL have parameter TICK_CLKS, default 30, meaning nominal clk_rx cycles per SENT tick (range 2..1000).
REQ-003 SHALL have port clk_rx, input, 1, the single clock for all logic.
REQ-004 SHALL have port reset_n_rx, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port sent_rx_i, input, 1, raw asynchronous SENT line.
REQ-006 SHALL have port sent_clean_o, output, 1, synchronized and glitch-filtered line level.
REQ-007 SHALL have port fall_o, output, 1, one-cycle strobe on each filtered falling edge.
REQ-008 SHALL have port pulse_valid_o, output, 1, one-cycle strobe marking a completed falling-to-falling interval.
REQ-009 SHALL have port pulse_len_o, output, 16, interval length in clk_rx cycles, held until the next pulse_valid_o.
REQ-010 SHALL have port pulse_ovf_o, output, 1, qualifies pulse_valid_o; interval saturated at 16'hFFFF.
REQ-011 SHALL have port calib_o, output, 1, one-cycle strobe when an interval falls inside the calibration window.
REQ-012 SHALL have port tick_len_o, output, 10, measured clk_rx cycles per tick, held until the next calibration.
REQ-013 SHALL have port tick_valid_o, output, 1, high once the first tick_len_o result is available.

Function
REQ-014 SHALL pass sent_rx_i through a two-flop synchronizer before any other use.
REQ-015 SHALL change sent_clean_o only after FILT_LEN consecutive synchronized samples differ from it; shorter glitches are ignored.
REQ-016 SHALL assert fall_o in the cycle after sent_clean_o goes 1->0; total latency from sent_rx_i edge = 2 + FILT_LEN cycles.
REQ-017 SHALL implement states IDLE (await first fall_o), MEASURE (count cycles since last fall).
REQ-018 SHALL move IDLE->MEASURE on fall_o with counter cleared to 1; no pulse_valid_o from IDLE.
REQ-019 SHALL, in MEASURE on fall_o, emit pulse_valid_o with pulse_len_o = counter value and restart the counter at 1 in the same cycle.
REQ-020 SHALL saturate the counter at 16'hFFFF, set pulse_ovf_o on the next pulse_valid_o, and never wrap.
REQ-021 SHALL define the calibration window as 56*TICK_CLKS*4/5 <= len <= 56*TICK_CLKS*6/5, integer arithmetic.
REQ-022 SHALL assert calib_o together with pulse_valid_o when len is in window and pulse_ovf_o is 0.
REQ-023 SHALL on calib_o start a sequential restoring divider computing (len+28)/56, one quotient bit per cycle, 16 cycles.
REQ-024 SHALL update tick_len_o (low 10 bits, saturate at 1023) and set tick_valid_o exactly 17 cycles after calib_o.
REQ-025 SHALL, on a new calib_o while the divider is busy, abort and restart with the new length (latest wins).
REQ-026 SHALL keep measuring pulses in parallel with the divider; divider activity never stalls pulse_valid_o.

Reset
REQ-027 SHALL on reset_n_rx low immediately force: state IDLE, sync/filter flops and sent_clean_o to 1 (SENT idle high), counter 0, divider idle.
REQ-028 SHALL reset all strobes, pulse_len_o, pulse_ovf_o, tick_len_o and tick_valid_o to 0.
REQ-029 SHALL, after reset mid-frame, produce no pulse_valid_o until two filtered falling edges have been seen.

Structure
REQ-030 SHALL take CALIB_TICKS=56, window numerator/denominator constants, and the 16/10-bit widths from the shared sent_rx package.
REQ-031 SHALL instantiate the divider as sub-module sent_rx_div56; synchronizer and filter stay inline.
REQ-032 SHALL be placed ahead of sent_rx_pulse_decode inside sent_rx_top, feeding it fall_o, pulse_len_o and tick_len_o.

Verification
REQ-033 Glitch: FILT_LEN=3, 2-cycle low glitch on idle line -> no fall_o, sent_clean_o stays 1.
REQ-034 Calibration: TICK_CLKS=30, falls 1680 cycles apart -> pulse_valid_o, pulse_len_o=1680, calib_o=1; 17 cycles later tick_len_o=30, tick_valid_o=1.
REQ-035 Window edges: intervals 1343 and 2017 -> calib_o=0; 1344 and 2016 -> calib_o=1, tick_len_o=24 and 36.
REQ-036 Overflow: line held low-high without fall for 70000 cycles -> pulse_len_o=16'hFFFF, pulse_ovf_o=1, calib_o=0.
REQ-037 Back-to-back: calibration of 1680 then of 1800 arriving 5 cycles later -> only tick_len_o=32 is ever published (rounded 32.14).
REQ-038 Reset mid-MEASURE: assert reset_n_rx for 1 cycle during a pulse -> all outputs 0, next pulse_valid_o only after second fall.
